// File: rtl/sync_up_counter_mod.sv
// Modulo-MOD synchronous up counter with enable, carry cascade, parallel load, prescaler and sticky overflow.
// Optional saturating mode (no wrap, no carry-out) is selected by defining SYNC_UP_COUNTER_MOD_SAT_EN.
module sync_up_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             cin,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout,
  output logic             ovf,
  output logic             lderr
);

  localparam int PSW = $clog2(PRESCALE) + 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] Q_LAST  = WIDTH'(MOD - 1);
  // The modulus may equal 2**WIDTH, so the load range check needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] r_q;
  logic [PSW-1:0]   r_ps;
  logic             r_ovf;
  logic             r_lderr;

  logic w_qual;
  logic w_step;
  logic w_tc;
  logic w_loadOk;

  assign w_qual   = en & cin;
  assign w_step   = w_qual & (r_ps == PS_LAST);
  assign w_tc     = (r_q == Q_LAST);
  assign w_loadOk = ({1'b0, load_val} < MOD_EXT);

  assign q     = r_q;
  assign tc    = w_tc;
  assign ovf   = r_ovf;
  assign lderr = r_lderr;

`ifdef SYNC_UP_COUNTER_MOD_SAT_EN
  assign cout = 1'b0;
`else
  assign cout = w_tc & w_step;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q     <= '0;
      r_ps    <= '0;
      r_ovf   <= 1'b0;
      r_lderr <= 1'b0;
    end else begin
      r_lderr <= 1'b0;
      // A same-cycle overflow below overrides this clear.
      if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (load) begin
        r_ps <= '0;
        if (w_loadOk) begin
          r_q <= load_val;
        end else begin
          r_q     <= '0;
          r_lderr <= 1'b1;
        end
      end else if (w_qual) begin
        if (w_step) begin
          r_ps <= '0;
          if (w_tc) begin
            r_ovf <= 1'b1;
`ifdef SYNC_UP_COUNTER_MOD_SAT_EN
            r_q   <= Q_LAST;
`else
            r_q   <= '0;
`endif
          end else begin
            r_q <= r_q + WIDTH'(1);
          end
        end else begin
          r_ps <= r_ps + PSW'(1);
        end
      end
    end
  end

endmodule
